// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the PIO family: Avalon register map and edge-capture modes.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_IRQMASK = 2'd1,
        REG_STATUS  = 2'd2,
        REG_EDGECAP = 2'd3
    } pio_reg_e;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Multi-flop synchronizer for asynchronous PIO inputs; shared by the PIO blocks.
module soc_system_pio_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[DEPTH-1];

endmodule

// File: rtl/soc_system_pio_capture.sv
// Avalon-MM input PIO with edge capture, W1C capture register and masked level interrupt.
module soc_system_pio_capture
    import soc_system_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] edge_q, edge_d;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
    logic [DATA_WIDTH-1:0] clr_mask;
    logic [31:0]           readdata_q, readdata_d;
    logic [31:0]           rd_mux;
    logic                  irq_q, irq_d;

    soc_system_pio_sync #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (in_port),
        .sync_o  (sync_q)
    );

    always_comb begin
        case (EDGE_MODE)
            EDGE_FALL: edge_d = ~sync_q & prev_q;
            EDGE_ANY:  edge_d = sync_q ^ prev_q;
            default:   edge_d = sync_q & ~prev_q;
        endcase
    end

    // Clear is applied before the OR so a coincident edge keeps the bit set.
    always_comb begin
        clr_mask  = (write && address == ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~clr_mask) | edge_q;
        irqmask_d = (write && address == ADDR_IRQMASK) ? writedata[DATA_WIDTH-1:0] : irqmask_q;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            ADDR_DATA:    rd_mux = 32'(sync_q);
            ADDR_IRQMASK: rd_mux = 32'(irqmask_q);
            ADDR_STATUS:  rd_mux = {irq_q, 30'd0, |edgecap_q};
            ADDR_EDGECAP: rd_mux = 32'(edgecap_q);
            default:      rd_mux = 32'd0;
        endcase
        readdata_d = read ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q     <= '0;
            edge_q     <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= sync_q;
            edge_q     <= edge_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: doc/soc_system_pio_capture.md
SOC_SYSTEM_PIO_CAPTURE -- requirements
Module: soc_system_pio_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the number of input bits (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on in_port (legal range 2..4).
REQ-003 SHALL have parameter EDGE_MODE, default 0, meaning the capture edge: 0 rising, 1 falling, 2 any.
REQ-004 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1 bit, a synchronous active-low reset sampled on the rising edge of clk.
REQ-006 SHALL have port address, input, 2 bits, the Avalon-MM word address.
REQ-007 SHALL have port read, input, 1 bit, the Avalon-MM read strobe.
REQ-008 SHALL have port write, input, 1 bit, the Avalon-MM write strobe.
REQ-009 SHALL have port writedata, input, 32 bits, the Avalon-MM write data.
REQ-010 SHALL have port in_port, input, DATA_WIDTH bits, the asynchronous external inputs.
REQ-011 SHALL have port readdata, output, 32 bits, the registered Avalon-MM read data.
REQ-012 SHALL have port irq, output, 1 bit, the level interrupt request.

Function
REQ-013 SHALL pass in_port through SYNC_STAGES flops to produce sync_q, and SHALL keep one further flop, prev_q, for edge detection.
REQ-014 SHALL use the register map 0 = DATA (RO, sync_q), 1 = IRQMASK (RW), 2 = STATUS (RO, {irq, 30'b0, |edgecap}), 3 = EDGECAP (RW1C).
REQ-015 SHALL compute edge_det per bit as follows: rising is sync_q & ~prev_q; falling is ~sync_q & prev_q; any is sync_q ^ prev_q.
REQ-016 SHALL set an edgecap bit in the cycle after its edge_det bit is high, and SHALL keep it sticky until it is cleared.
REQ-017 SHALL, on a write to address 3, clear each edgecap bit whose writedata bit is 1.
REQ-018 SHALL let set win when edge_det and a clear hit the same bit in the same cycle, so the bit remains 1.
REQ-019 SHALL load IRQMASK[DATA_WIDTH-1:0] from writedata on a write to address 1.
REQ-020 SHALL register irq as |(edgecap & irqmask), giving one cycle of latency after the edgecap or irqmask update.
REQ-021 SHALL register readdata one cycle after a cycle with read=1; it SHALL be the selected register zero-extended to 32 bits.
REQ-022 SHALL set readdata to 0 when read=0.
REQ-023 SHALL ignore writes to addresses 0 and 2.
REQ-024 SHALL tie upper bits [31:DATA_WIDTH] to zero on every read.
REQ-025 SHALL give an input change a latency to DATA of SYNC_STAGES+1 cycles to readdata.
REQ-026 SHALL give an edge a latency to irq of SYNC_STAGES+3 cycles, counted from the first clk edge at which the new in_port level is sampled.
REQ-027 SHALL have the following boundary behaviour when DATA_WIDTH=1: STATUS and all register widths remain legal.

Reset
REQ-028 SHALL, while reset_n=0 at a clk edge, clear the sync flops, prev_q, edgecap, irqmask, readdata and irq to 0.
REQ-029 SHALL produce no edge from the reset-release transition itself, because prev_q and sync_q both restart from 0.
REQ-030 SHALL produce a rising capture at the normal latency for an input already high at release.
REQ-031 SHALL, on reset asserted mid-operation, discard pending captures with no irq glitch; irq SHALL be 0 in the first cycle after the reset edge.

Structure
REQ-032 SHALL place the address constants ADDR_DATA, ADDR_IRQMASK, ADDR_STATUS and ADDR_EDGECAP, and the edge-mode constants EDGE_RISE, EDGE_FALL and EDGE_ANY, in the shared package soc_system_pio_pkg.
REQ-033 SHALL use one sub-module, soc_system_pio_sync (parametrised width and depth, synchronous active-low reset), which later PIO blocks SHALL reuse.
REQ-034 SHALL keep all other logic in soc_system_pio_capture.

Verification
REQ-035 SHALL cover DATA readback: DATA_WIDTH=8, drive in_port=8'hA5, wait 4 cycles, read address 0 -> readdata=32'h000000A5 one cycle after read.
REQ-036 SHALL cover rising capture and irq: EDGE_MODE=0, IRQMASK=8'h01, in_port bit0 0->1 -> edgecap=8'h01 and irq=1 exactly SYNC_STAGES+3 cycles later; STATUS reads 32'h80000001.
REQ-037 SHALL cover the masked edge: IRQMASK=0, toggle bit3 -> EDGECAP reads 8'h08 and irq stays 0; then write IRQMASK=8'h08 -> irq=1 one cycle after the write.
REQ-038 SHALL cover clear: write 32'h08 to address 3 -> EDGECAP reads 0, irq falls one cycle after the clear.
REQ-039 SHALL cover the simultaneous edge and clear: a W1C to bit0 in the same cycle as a detected edge on bit0 -> bit0 stays 1 and irq stays 1.
REQ-040 SHALL cover mid-operation reset: irq=1 with edgecap=8'hFF, assert reset_n=0 for 1 cycle -> all reads return 0, irq=0, and no capture after release with in_port held constant at 0.
